// File: rtl/alu_pkg.sv
// Shared widths, command encodings and collector state type for the ALU slice.
// needOperands() classifies a command as needing A only, B only, or both operands.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int ALU_N = 4;

    typedef enum logic [ALU_N-1:0] {
        ARITH_ADD     = 4'd0,
        ARITH_SUB     = 4'd1,
        ARITH_ADD_CIN = 4'd2,
        ARITH_SUB_CIN = 4'd3,
        ARITH_INC_A   = 4'd4,
        ARITH_DEC_A   = 4'd5,
        ARITH_INC_B   = 4'd6,
        ARITH_DEC_B   = 4'd7,
        ARITH_CMP     = 4'd8
    } arith_cmd_e;

    typedef enum logic [ALU_N-1:0] {
        LOGIC_AND     = 4'd0,
        LOGIC_NAND    = 4'd1,
        LOGIC_OR      = 4'd2,
        LOGIC_NOR     = 4'd3,
        LOGIC_XOR     = 4'd4,
        LOGIC_XNOR    = 4'd5,
        LOGIC_NOT_A   = 4'd6,
        LOGIC_NOT_B   = 4'd7,
        LOGIC_SHR1_A  = 4'd8,
        LOGIC_SHL1_A  = 4'd9,
        LOGIC_SHR1_B  = 4'd10,
        LOGIC_SHL1_B  = 4'd11,
        LOGIC_ROL_A_B = 4'd12,
        LOGIC_ROR_A_B = 4'd13
    } logic_cmd_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_A,
        S_WAIT_B
    } collect_state_e;

    // Result bit0 = needs A, bit1 = needs B; invalid codes count as two-operand.
    function automatic logic [1:0] needOperands(input logic mode, input logic [ALU_N-1:0] cmd);
        logic [1:0] need;
        need = 2'b11;
        if (mode) begin
            case (cmd)
                ARITH_INC_A, ARITH_DEC_A: need = 2'b01;
                ARITH_INC_B, ARITH_DEC_B: need = 2'b10;
                default:                  need = 2'b11;
            endcase
        end else begin
            case (cmd)
                LOGIC_NOT_A, LOGIC_SHR1_A, LOGIC_SHL1_A: need = 2'b01;
                LOGIC_NOT_B, LOGIC_SHR1_B, LOGIC_SHL1_B: need = 2'b10;
                default:                                 need = 2'b11;
            endcase
        end
        return need;
    endfunction

endpackage

// File: rtl/alu_operand_collector.sv
// Gathers operands that may arrive in separate cycles and decides when to execute.
// Emits single-cycle exec/timeout strobes plus the operand set the datapath must use.
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int W = ALU_W,
    parameter int N = ALU_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ce,
    input  logic [W-1:0] i_opa,
    input  logic [W-1:0] i_opb,
    input  logic         i_cin,
    input  logic         i_mode,
    input  logic [1:0]   i_inp_valid,
    input  logic [N-1:0] i_cmd,
    output logic         o_exec,
    output logic         o_timeout,
    output logic [W-1:0] o_opa,
    output logic [W-1:0] o_opb,
    output logic         o_cin,
    output logic         o_mode,
    output logic [N-1:0] o_cmd
);

    collect_state_e r_state;
    collect_state_e w_nextState;
    logic [3:0]     r_waitCnt;
    logic [W-1:0]   r_opa;
    logic [W-1:0]   r_opb;
    logic [N-1:0]   r_cmd;
    logic           r_mode;
    logic           r_cin;
    logic [1:0]     w_need;
    logic           w_capA;
    logic           w_capB;

    always_comb begin
        w_need      = needOperands(i_mode, i_cmd);
        w_nextState = r_state;
        w_capA      = 1'b0;
        w_capB      = 1'b0;
        o_exec      = 1'b0;
        o_timeout   = 1'b0;
        o_opa       = i_opa;
        o_opb       = i_opb;
        o_cin       = i_cin;
        o_mode      = i_mode;
        o_cmd       = i_cmd;
        case (r_state)
            S_IDLE: begin
                if (i_ce) begin
                    if ((w_need & i_inp_valid) == w_need) begin
                        o_exec = 1'b1;
                    end else if (w_need == 2'b11 && i_inp_valid == 2'b01) begin
                        w_capA      = 1'b1;
                        w_nextState = S_WAIT_B;
                    end else if (w_need == 2'b11 && i_inp_valid == 2'b10) begin
                        w_capB      = 1'b1;
                        w_nextState = S_WAIT_A;
                    end
                end
            end
            // A full count of 15 means this is the 16th waiting cycle: timeout wins over arrival.
            S_WAIT_B: begin
                o_opa  = r_opa;
                o_cin  = r_cin;
                o_mode = r_mode;
                o_cmd  = r_cmd;
                if (i_ce) begin
                    if (r_waitCnt == 4'hF) begin
                        o_timeout   = 1'b1;
                        w_nextState = S_IDLE;
                    end else if (i_inp_valid[1]) begin
                        o_exec      = 1'b1;
                        w_nextState = S_IDLE;
                    end
                end
            end
            S_WAIT_A: begin
                o_opb  = r_opb;
                o_cin  = r_cin;
                o_mode = r_mode;
                o_cmd  = r_cmd;
                if (i_ce) begin
                    if (r_waitCnt == 4'hF) begin
                        o_timeout   = 1'b1;
                        w_nextState = S_IDLE;
                    end else if (i_inp_valid[0]) begin
                        o_exec      = 1'b1;
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_waitCnt <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_cmd     <= '0;
            r_mode    <= 1'b0;
            r_cin     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (i_ce && r_state != S_IDLE) begin
                r_waitCnt <= (w_nextState == S_IDLE) ? 4'd0 : r_waitCnt + 4'd1;
            end
            if (w_capA) begin
                r_opa  <= i_opa;
                r_cmd  <= i_cmd;
                r_mode <= i_mode;
                r_cin  <= i_cin;
            end
            if (w_capB) begin
                r_opb  <= i_opb;
                r_cmd  <= i_cmd;
                r_mode <= i_mode;
                r_cin  <= i_cin;
            end
        end
    end

endmodule

// File: rtl/alu_core.sv
// ALU top: operand collector, combinational datapath and registered result/flag stage.
// Each output carries its own drive-enable so undefined results and flags float.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = ALU_W,
    parameter int N = ALU_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ce,
    input  logic [W-1:0] i_opa,
    input  logic [W-1:0] i_opb,
    input  logic         i_cin,
    input  logic         i_mode,
    input  logic [1:0]   i_inp_valid,
    input  logic [N-1:0] i_cmd,
    output logic [W:0]   o_res,
    output logic         o_cout,
    output logic         o_oflow,
    output logic         o_g,
    output logic         o_l,
    output logic         o_e,
    output logic         o_err
);

    localparam int AW = $clog2(W);
    localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

    logic          w_exec, w_timeout, w_cin, w_mode;
    logic [W-1:0]  w_opa, w_opb, w_rol, w_ror;
    logic [N-1:0]  w_cmd;
    logic [W:0]    w_a1, w_b1, w_c1, w_res;
    logic [AW-1:0] w_rotAmt;
    logic          w_rotErr;
    logic          w_resOn, w_cout, w_coutOn, w_oflow, w_oflowOn;
    logic          w_g, w_l, w_e, w_cmpOn, w_err;

    logic [W:0]    r_res;
    logic          r_resOn, r_cout, r_coutOn, r_oflow, r_oflowOn;
    logic          r_g, r_l, r_e, r_cmpOn, r_err, r_errOn;

    alu_operand_collector #(.W(W), .N(N)) u_collector (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ce        (i_ce),
        .i_opa       (i_opa),
        .i_opb       (i_opb),
        .i_cin       (i_cin),
        .i_mode      (i_mode),
        .i_inp_valid (i_inp_valid),
        .i_cmd       (i_cmd),
        .o_exec      (w_exec),
        .o_timeout   (w_timeout),
        .o_opa       (w_opa),
        .o_opb       (w_opb),
        .o_cin       (w_cin),
        .o_mode      (w_mode),
        .o_cmd       (w_cmd)
    );

    assign w_a1     = {1'b0, w_opa};
    assign w_b1     = {1'b0, w_opb};
    assign w_c1     = {{W{1'b0}}, w_cin};
    assign w_rotAmt = w_opb[AW-1:0];
    assign w_rotErr = |w_opb[W-1:AW];
    assign w_rol    = (w_opa << w_rotAmt) | (w_opa >> (W - int'(w_rotAmt)));
    assign w_ror    = (w_opa >> w_rotAmt) | (w_opa << (W - int'(w_rotAmt)));

    // Subtractions wrap in W+1 bits so the top bit doubles as the borrow.
    always_comb begin
        w_res     = '0;
        w_resOn   = 1'b1;
        w_coutOn  = 1'b0;
        w_oflowOn = 1'b0;
        w_g       = 1'b0;
        w_l       = 1'b0;
        w_e       = 1'b0;
        w_cmpOn   = 1'b0;
        w_err     = 1'b0;
        if (w_mode) begin
            case (w_cmd)
                ARITH_ADD:     begin w_res = w_a1 + w_b1;        w_coutOn  = 1'b1; end
                ARITH_SUB:     begin w_res = w_a1 - w_b1;        w_oflowOn = 1'b1; end
                ARITH_ADD_CIN: begin w_res = w_a1 + w_b1 + w_c1; w_coutOn  = 1'b1; end
                ARITH_SUB_CIN: begin w_res = w_a1 - w_b1 - w_c1; w_oflowOn = 1'b1; end
                ARITH_INC_A:   begin w_res = w_a1 + ONE;         w_coutOn  = 1'b1; end
                ARITH_DEC_A:   begin w_res = w_a1 - ONE;         w_oflowOn = 1'b1; end
                ARITH_INC_B:   begin w_res = w_b1 + ONE;         w_coutOn  = 1'b1; end
                ARITH_DEC_B:   begin w_res = w_b1 - ONE;         w_oflowOn = 1'b1; end
                ARITH_CMP: begin
                    w_cmpOn = 1'b1;
                    w_g     = w_opa > w_opb;
                    w_l     = w_opa < w_opb;
                    w_e     = w_opa == w_opb;
                end
                default: begin w_err = 1'b1; w_resOn = 1'b0; end
            endcase
        end else begin
            case (w_cmd)
                LOGIC_AND:     w_res = {1'b0, w_opa & w_opb};
                LOGIC_NAND:    w_res = {1'b0, ~(w_opa & w_opb)};
                LOGIC_OR:      w_res = {1'b0, w_opa | w_opb};
                LOGIC_NOR:     w_res = {1'b0, ~(w_opa | w_opb)};
                LOGIC_XOR:     w_res = {1'b0, w_opa ^ w_opb};
                LOGIC_XNOR:    w_res = {1'b0, ~(w_opa ^ w_opb)};
                LOGIC_NOT_A:   w_res = {1'b0, ~w_opa};
                LOGIC_NOT_B:   w_res = {1'b0, ~w_opb};
                LOGIC_SHR1_A:  w_res = {1'b0, w_opa >> 1};
                LOGIC_SHL1_A:  w_res = {1'b0, w_opa << 1};
                LOGIC_SHR1_B:  w_res = {1'b0, w_opb >> 1};
                LOGIC_SHL1_B:  w_res = {1'b0, w_opb << 1};
                LOGIC_ROL_A_B: begin w_res = {1'b0, w_rol}; w_err = w_rotErr; end
                LOGIC_ROR_A_B: begin w_res = {1'b0, w_ror}; w_err = w_rotErr; end
                default: begin w_err = 1'b1; w_resOn = 1'b0; end
            endcase
        end
        w_cout  = w_res[W];
        w_oflow = w_res[W];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res     <= '0;
            r_resOn   <= 1'b0;
            r_cout    <= 1'b0;
            r_coutOn  <= 1'b0;
            r_oflow   <= 1'b0;
            r_oflowOn <= 1'b0;
            r_g       <= 1'b0;
            r_l       <= 1'b0;
            r_e       <= 1'b0;
            r_cmpOn   <= 1'b0;
            r_err     <= 1'b0;
            r_errOn   <= 1'b0;
        end else if (w_timeout) begin
            r_resOn   <= 1'b0;
            r_coutOn  <= 1'b0;
            r_oflowOn <= 1'b0;
            r_cmpOn   <= 1'b0;
            r_err     <= 1'b1;
            r_errOn   <= 1'b1;
        end else if (w_exec) begin
            r_res     <= w_res;
            r_resOn   <= w_resOn;
            r_cout    <= w_cout;
            r_coutOn  <= w_coutOn;
            r_oflow   <= w_oflow;
            r_oflowOn <= w_oflowOn;
            r_g       <= w_g;
            r_l       <= w_l;
            r_e       <= w_e;
            r_cmpOn   <= w_cmpOn;
            r_err     <= w_err;
            r_errOn   <= 1'b1;
        end
    end

    assign o_res   = r_resOn   ? r_res   : 'z;
    assign o_cout  = r_coutOn  ? r_cout  : 1'bz;
    assign o_oflow = r_oflowOn ? r_oflow : 1'bz;
    assign o_g     = r_cmpOn   ? r_g     : 1'bz;
    assign o_l     = r_cmpOn   ? r_l     : 1'bz;
    assign o_e     = r_cmpOn   ? r_e     : 1'bz;
    assign o_err   = r_errOn   ? r_err   : 1'bz;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed test-plan cases plus randomized traffic,
// all compared every cycle against an arithmetic model of the ALU's documented behaviour.
module tb_alu_core;

    logic       clk = 1'b0;
    logic       rst, ce, cin, mode;
    logic [1:0] inpValid;
    logic [3:0] cmd;
    logic [7:0] opa, opb;
    wire  [8:0] res;
    wire        cout, oflow, g, l, e, err;

    int testsRun    = 0;
    int testsFailed = 0;

    // Expected output values and whether each one is actively driven.
    logic [8:0] eRes;
    logic       eCout, eOfl, eG, eL, eE, eErr;
    logic       eResOn = 1'b0, eCoutOn = 1'b0, eOflOn = 1'b0, eCmpOn = 1'b0, eErrOn = 1'b0;

    // Pending-operation bookkeeping: 0 none, 1 waiting for B, 2 waiting for A.
    int         mPend = 0;
    int         mCnt  = 0;
    logic [7:0] mA, mB;
    logic [3:0] mCmd;
    logic       mMode, mCin;

    always #5 clk = ~clk;

    alu_core #(.W(8), .N(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ce        (ce),
        .i_opa       (opa),
        .i_opb       (opb),
        .i_cin       (cin),
        .i_mode      (mode),
        .i_inp_valid (inpValid),
        .i_cmd       (cmd),
        .o_res       (res),
        .o_cout      (cout),
        .o_oflow     (oflow),
        .o_g         (g),
        .o_l         (l),
        .o_e         (e),
        .o_err       (err)
    );

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] needOf(input logic m, input logic [3:0] c);
        if (m) begin
            if (c == 4 || c == 5) return 2'b01;
            if (c == 6 || c == 7) return 2'b10;
        end else begin
            if (c == 6 || c == 8 || c == 9)   return 2'b01;
            if (c == 7 || c == 10 || c == 11) return 2'b10;
        end
        return 2'b11;
    endfunction

    task automatic modelExec(input logic m, input logic [3:0] c, input logic [7:0] a,
                             input logic [7:0] b, input logic ci);
        int ia, ib, r, amt;
        ia = a; ib = b; r = 0; amt = ib % 8;
        eResOn = 1'b1; eCoutOn = 1'b0; eOflOn = 1'b0; eCmpOn = 1'b0;
        eErrOn = 1'b1; eErr = 1'b0; eG = 1'b0; eL = 1'b0; eE = 1'b0;
        if (m) begin
            case (c)
                0: begin r = ia + ib;      eCoutOn = 1'b1; end
                1: begin r = ia - ib;      eOflOn  = 1'b1; end
                2: begin r = ia + ib + ci; eCoutOn = 1'b1; end
                3: begin r = ia - ib - ci; eOflOn  = 1'b1; end
                4: begin r = ia + 1;       eCoutOn = 1'b1; end
                5: begin r = ia - 1;       eOflOn  = 1'b1; end
                6: begin r = ib + 1;       eCoutOn = 1'b1; end
                7: begin r = ib - 1;       eOflOn  = 1'b1; end
                8: begin r = 0; eCmpOn = 1'b1; eG = (ia > ib); eL = (ia < ib); eE = (ia == ib); end
                default: begin eResOn = 1'b0; eErr = 1'b1; end
            endcase
            eRes = r[8:0];
        end else begin
            case (c)
                0:  r = ia & ib;
                1:  r = ~(ia & ib);
                2:  r = ia | ib;
                3:  r = ~(ia | ib);
                4:  r = ia ^ ib;
                5:  r = ~(ia ^ ib);
                6:  r = ~ia;
                7:  r = ~ib;
                8:  r = ia / 2;
                9:  r = ia * 2;
                10: r = ib / 2;
                11: r = ib * 2;
                12: begin r = (ia << amt) | (ia >> (8 - amt)); eErr = (ib > 7); end
                13: begin r = (ia >> amt) | (ia << (8 - amt)); eErr = (ib > 7); end
                default: begin eResOn = 1'b0; eErr = 1'b1; end
            endcase
            eRes = {1'b0, r[7:0]};
        end
        eCout = eRes[8];
        eOfl  = eRes[8];
    endtask

    task automatic modelStep(input logic r, input logic en, input logic [1:0] v, input logic m,
                             input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                             input logic ci);
        logic [1:0] n;
        if (r) begin
            eResOn = 1'b0; eCoutOn = 1'b0; eOflOn = 1'b0; eCmpOn = 1'b0; eErrOn = 1'b0;
            mPend = 0; mCnt = 0;
        end else if (en) begin
            if (mPend == 0) begin
                n = needOf(m, c);
                if ((n & v) == n) begin
                    modelExec(m, c, a, b, ci);
                end else if (n == 2'b11 && v != 2'b00) begin
                    mPend = (v == 2'b01) ? 1 : 2;
                    mA = a; mB = b; mCmd = c; mMode = m; mCin = ci; mCnt = 0;
                end
            end else if (mCnt == 15) begin
                eResOn = 1'b0; eCoutOn = 1'b0; eOflOn = 1'b0; eCmpOn = 1'b0;
                eErrOn = 1'b1; eErr = 1'b1; mPend = 0;
            end else if (mPend == 1 && v[1]) begin
                modelExec(mMode, mCmd, mA, b, mCin);
                mPend = 0;
            end else if (mPend == 2 && v[0]) begin
                modelExec(mMode, mCmd, a, mB, mCin);
                mPend = 0;
            end else begin
                mCnt++;
            end
        end
    endtask

    task automatic checkOutput();
        if (eResOn)  compareVal("res", 32'(res), 32'(eRes));
        if (eCoutOn) compareVal("cout", 32'(cout), 32'(eCout));
        if (eOflOn)  compareVal("oflow", 32'(oflow), 32'(eOfl));
        if (eCmpOn) begin
            compareVal("g", 32'(g), 32'(eG));
            compareVal("l", 32'(l), 32'(eL));
            compareVal("e", 32'(e), 32'(eE));
        end
        if (eErrOn)  compareVal("err", 32'(err), 32'(eErr));
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic [1:0] v, input logic m,
                                 input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci);
        @(negedge clk);
        rst = r; ce = en; inpValid = v; mode = m; cmd = c; opa = a; opb = b; cin = ci;
        @(posedge clk);
        modelStep(r, en, v, m, c, a, b, ci);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; inpValid = 2'b00; mode = 1'b0; cmd = 4'd0;
        opa = 8'h00; opb = 8'h00; cin = 1'b0;
        applyStimulus(1, 1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0);
        applyStimulus(1, 1, 2'b00, 0, 4'd0, 8'h00, 8'h00, 0);

        // ADD with carry out.
        applyStimulus(0, 1, 2'b11, 1, 4'd0, 8'hFF, 8'h01, 0);
        compareVal("add_res_lit", 32'(res), 32'h100);
        compareVal("add_cout_lit", 32'(cout), 32'h1);
        compareVal("add_model_lit", 32'(eRes), 32'h100);

        // CMP 5 vs 9.
        applyStimulus(0, 1, 2'b11, 1, 4'd8, 8'd5, 8'd9, 0);
        compareVal("cmp_l_lit", 32'(l), 32'h1);
        compareVal("cmp_g_lit", 32'(g), 32'h0);
        compareVal("cmp_e_lit", 32'(e), 32'h0);
        compareVal("cmp_res_lit", 32'(res), 32'h0);

        // Split SUB: A first, five idle cycles with junk command fields, then B.
        applyStimulus(0, 1, 2'b01, 1, 4'd1, 8'h10, 8'hAA, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 2'b00, 0, 4'd3, 8'h55, 8'h66, 1);
        applyStimulus(0, 1, 2'b10, 0, 4'd2, 8'h77, 8'h03, 1);
        compareVal("split_sub_res_lit", 32'(res), 32'h00D);
        compareVal("split_sub_err_lit", 32'(err), 32'h0);
        compareVal("split_sub_model_lit", 32'(eRes), 32'h00D);

        // Timeout: sixteen CE cycles with nothing arriving.
        applyStimulus(0, 1, 2'b01, 1, 4'd1, 8'h10, 8'h00, 0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 2'b00, 1, 4'd0, 8'h00, 8'h00, 0);
        compareVal("timeout_pre_err_lit", 32'(err), 32'h0);
        applyStimulus(0, 1, 2'b00, 1, 4'd0, 8'h00, 8'h00, 0);
        compareVal("timeout_err_lit", 32'(err), 32'h1);
        applyStimulus(0, 1, 2'b11, 1, 4'd0, 8'h03, 8'h04, 0);
        compareVal("post_timeout_add_lit", 32'(res), 32'h007);
        compareVal("post_timeout_err_lit", 32'(err), 32'h0);

        // ROL by 1 with an out-of-range amount bit set.
        applyStimulus(0, 1, 2'b11, 0, 4'd12, 8'h81, 8'h11, 0);
        compareVal("rol_res_lit", 32'(res), 32'h003);
        compareVal("rol_err_lit", 32'(err), 32'h1);

        // CE=0 cycles stretch the wait window beyond sixteen clocks.
        applyStimulus(0, 1, 2'b01, 1, 4'd0, 8'h40, 8'h00, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 2'b10, 1, 4'd1, 8'h00, 8'h99, 0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 1, 2'b00, 1, 4'd1, 8'h00, 8'h00, 0);
        applyStimulus(0, 1, 2'b10, 1, 4'd1, 8'h00, 8'h02, 0);
        compareVal("ce_stretch_res_lit", 32'(res), 32'h042);

        // Reset while waiting for B: the late B starts a fresh ADD instead of finishing the SUB.
        applyStimulus(0, 1, 2'b01, 1, 4'd1, 8'h20, 8'h00, 0);
        applyStimulus(1, 1, 2'b00, 1, 4'd1, 8'h00, 8'h00, 0);
        applyStimulus(0, 1, 2'b10, 1, 4'd0, 8'h00, 8'h05, 0);
        applyStimulus(0, 1, 2'b01, 1, 4'd1, 8'h07, 8'h00, 0);
        compareVal("reset_abort_res_lit", 32'(res), 32'h00C);
        compareVal("reset_abort_cout_lit", 32'(cout), 32'h0);

        // Random traffic; every third phase starves operands so timeouts occur.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] v;
            if ((i / 150) % 3 == 2)
                v = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            else
                v = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), v,
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
